multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multi-cycle sequencer for the 32-bit RV32I-subset datapath (register file, immediate generator, ALU, data memory).
- Owns the PC and the instruction register (IR) and fetches over a req/ack instruction-memory handshake.
- Decodes IR and drives the datapath controls one phase at a time, so register and memory writes occur only in their dedicated states.
- Resolves branches from the datapath Zero/Sign flags and Imm.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, PC increment for sequential flow.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request, held high through the FETCH state.
- imem_addr  out  32  fetch address, equal to PC.
- imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- Instruction  out  32  IR contents, fed to the datapath.
- RegWrite, ALUSrc, MemWrite, MemRead, MemToReg  out  1 each  datapath controls.
- ALUControl  out  4  ALU operation select.
- Zero, Sign  in  1 each  ALU flags from the datapath.
- Imm  in  32  immediate from the datapath immediate generator.
- dmem_ready  in  1  data-memory access complete.
- pc  out  32  current PC.
- halted  out  1  high in the TRAP state.

Behaviour:
- Reset (async, RST_N=0):
  - PC=RESET_PC, IR=32'h0000_0013 (NOP), state=FETCH.
  - All control outputs 0, ALUControl=0000, halted=0, imem_req=0.
  - imem_req first rises in the first cycle after reset deasserts.
  - Reset mid-operation aborts any pending fetch or memory access immediately.
- ALUControl encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On a cycle with imem_ack=1: IR<=imem_rdata, go to DECODE.
  - Otherwise stay in FETCH; there is no timeout.
- DECODE (1 cycle):
  - Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 LW (funct3=010 only), 0100011 SW (funct3=010 only), 1100011 branch (funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE).
  - Anything else goes to TRAP.
  - R-type with funct7 other than 0000000/0100000 goes to TRAP. funct7=0100000 is legal only with funct3 000 or 101; other combinations go to TRAP.
  - Otherwise go to EXEC.
- ALUControl and ALUSrc: driven from EXEC through the end of WB/MEM and held stable for the whole instruction.
  - R-type: funct3 000 gives ADD, or SUB when funct7[5]=1; 111 AND; 110 OR; 100 XOR; 001 SLL; 101 gives SRL, or SRA when funct7[5]=1; 010 SLT; 011 SLTU.
  - I-ALU: same mapping, except 000 is always ADD and 101 selects SRA via IR[30].
  - LW/SW: ADD. Branch: SUB.
  - ALUSrc=1 for I-ALU/LW/SW, 0 for R/branch.
- EXEC (1 cycle):
  - R/I-ALU go to WB. LW/SW go to MEM.
  - Branch resolves here. Taken: BEQ Zero=1, BNE Zero=0, BLT Sign=1, BGE Sign=0; signed overflow is ignored.
  - Taken: PC<=PC+Imm. Not taken: PC<=PC+PC_STEP. Then go to FETCH.
- MEM:
  - MemRead=1 (LW) or MemWrite=1 (SW), held until a cycle with dmem_ready=1.
  - A repeated write of the same address/data during wait cycles is permitted.
  - On ready: LW goes to WB; SW sets PC+=PC_STEP and goes to FETCH.
- WB (1 cycle):
  - RegWrite=1, with MemToReg=1 for LW and 0 otherwise.
  - PC+=PC_STEP, go to FETCH.
  - RegWrite is never high in any other state. Writes to x0 are the register file's concern.
- TRAP: halted=1, all writes deasserted, imem_req=0. Held until reset.
- PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- Latency with zero wait states: branch 3 cycles, R/I/SW 4, LW 5.

Test Plan:
- Reset with RESET_PC=32'h100 and imem_ack tied 1 → imem_addr=32'h100 in the first post-reset cycle; all controls 0 during reset.
- ADD x3,x1,x2 (32'h002081B3) with immediate ack → RegWrite=1 for exactly one cycle, 3 cycles after the fetch cycle. ALUControl=0000, ALUSrc=0, MemToReg=0. Next imem_addr=PC+4.
- LW x5,8(x1) with dmem_ready low for 3 MEM cycles → MemRead high for 4 cycles, then a WB cycle with RegWrite=1 and MemToReg=1. MemWrite stays 0 throughout.
- BEQ with Imm=-8, PC=32'h40: Zero=1 → next imem_addr=32'h38; Zero=0 → 32'h44. BLT with Sign=1 → taken.
- Illegal opcode 32'hFFFFFFFF → halted=1 after DECODE; no RegWrite/MemWrite afterwards; imem_req stays 0 until RST_N pulses.
- RST_N asserted mid-MEM during an SW wait → MemWrite drops immediately; PC=RESET_PC; fetch restarts after release.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Instruction-fetch handshake plus datapath control/status bundle for the multi-cycle sequencer.
// master = control unit side, slave = memory/datapath side.
interface multicycle_control_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        reg_write;
  logic        alu_src;
  logic        mem_write;
  logic        mem_read;
  logic        mem_to_reg;
  logic [3:0]  alu_control;
  logic        zero;
  logic        sign;
  logic [31:0] imm;
  logic        dmem_ready;
  logic [31:0] pc;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instruction, reg_write, alu_src, mem_write,
           mem_read, mem_to_reg, alu_control, pc, halted,
    input  imem_ack, imem_rdata, zero, sign, imm, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, instruction, reg_write, alu_src, mem_write,
           mem_read, mem_to_reg, alu_control, pc, halted,
    output imem_ack, imem_rdata, zero, sign, imm, dmem_ready
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I-subset sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP with PC and IR ownership.
// Every control output is a register updated on state transitions.
module multicycle_control_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_control_unit_if.master  bus
);

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_I     = 7'b0010011;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [6:0]  OP_BR    = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic        imem_req_reg;
  logic        reg_write_reg;
  logic        alu_src_reg;
  logic        mem_write_reg;
  logic        mem_read_reg;
  logic        mem_to_reg_reg;
  logic        halted_reg;
  logic [3:0]  alu_control_reg;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_r, is_i, is_lw, is_sw, is_br, legal, br_taken;
  logic [3:0] alu_code;

  assign opcode = ir_reg[6:0];
  assign funct3 = ir_reg[14:12];
  assign funct7 = ir_reg[31:25];

  always_comb begin
    is_r  = (opcode == OP_R);
    is_i  = (opcode == OP_I);
    is_lw = (opcode == OP_LOAD)  && (funct3 == 3'b010);
    is_sw = (opcode == OP_STORE) && (funct3 == 3'b010);
    is_br = (opcode == OP_BR) &&
            ((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b101));
    legal = (is_r && ((funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
            || is_i || is_lw || is_sw || is_br;
  end

  // IR[30] is funct7[5] for R-type and the SRAI marker for I-type; ADDI never subtracts.
  always_comb begin
    alu_code = ALU_ADD;
    case (funct3)
      3'b000:  alu_code = (is_r && ir_reg[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_code = ALU_SLL;
      3'b010:  alu_code = ALU_SLT;
      3'b011:  alu_code = ALU_SLTU;
      3'b100:  alu_code = ALU_XOR;
      3'b101:  alu_code = ir_reg[30] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_code = ALU_OR;
      default: alu_code = ALU_AND;
    endcase
    if (is_lw || is_sw) alu_code = ALU_ADD;
    if (is_br)          alu_code = ALU_SUB;
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = bus.zero;
      3'b001:  br_taken = ~bus.zero;
      3'b100:  br_taken = bus.sign;
      3'b101:  br_taken = ~bus.sign;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_FETCH;
      pc_reg          <= RESET_PC;
      ir_reg          <= NOP_INSN;
      imem_req_reg    <= 1'b0;
      reg_write_reg   <= 1'b0;
      alu_src_reg     <= 1'b0;
      mem_write_reg   <= 1'b0;
      mem_read_reg    <= 1'b0;
      mem_to_reg_reg  <= 1'b0;
      halted_reg      <= 1'b0;
      alu_control_reg <= ALU_ADD;
    end else begin
      case (state_reg)
        S_FETCH: begin
          // Request is raised one cycle into FETCH after reset; an ack is only honoured while it is up.
          if (!imem_req_reg) begin
            imem_req_reg <= 1'b1;
          end else if (bus.imem_ack) begin
            ir_reg       <= bus.imem_rdata;
            imem_req_reg <= 1'b0;
            state_reg    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (legal) begin
            alu_control_reg <= alu_code;
            alu_src_reg     <= is_i || is_lw || is_sw;
            state_reg       <= S_EXEC;
          end else begin
            halted_reg <= 1'b1;
            state_reg  <= S_TRAP;
          end
        end
        S_EXEC: begin
          if (is_br) begin
            pc_reg          <= br_taken ? (pc_reg + bus.imm) : (pc_reg + PC_STEP);
            alu_control_reg <= ALU_ADD;
            alu_src_reg     <= 1'b0;
            imem_req_reg    <= 1'b1;
            state_reg       <= S_FETCH;
          end else if (is_lw || is_sw) begin
            mem_read_reg  <= is_lw;
            mem_write_reg <= is_sw;
            state_reg     <= S_MEM;
          end else begin
            reg_write_reg  <= 1'b1;
            mem_to_reg_reg <= 1'b0;
            state_reg      <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            if (is_lw) begin
              reg_write_reg  <= 1'b1;
              mem_to_reg_reg <= 1'b1;
              state_reg      <= S_WB;
            end else begin
              pc_reg          <= pc_reg + PC_STEP;
              alu_control_reg <= ALU_ADD;
              alu_src_reg     <= 1'b0;
              imem_req_reg    <= 1'b1;
              state_reg       <= S_FETCH;
            end
          end
        end
        S_WB: begin
          reg_write_reg   <= 1'b0;
          mem_to_reg_reg  <= 1'b0;
          pc_reg          <= pc_reg + PC_STEP;
          alu_control_reg <= ALU_ADD;
          alu_src_reg     <= 1'b0;
          imem_req_reg    <= 1'b1;
          state_reg       <= S_FETCH;
        end
        S_TRAP: begin
          halted_reg <= 1'b1;
        end
        default: begin
          halted_reg <= 1'b1;
          state_reg  <= S_TRAP;
        end
      endcase
    end
  end

  assign bus.imem_req    = imem_req_reg;
  assign bus.imem_addr   = pc_reg;
  assign bus.instruction = ir_reg;
  assign bus.reg_write   = reg_write_reg;
  assign bus.alu_src     = alu_src_reg;
  assign bus.mem_write   = mem_write_reg;
  assign bus.mem_read    = mem_read_reg;
  assign bus.mem_to_reg  = mem_to_reg_reg;
  assign bus.alu_control = alu_control_reg;
  assign bus.pc          = pc_reg;
  assign bus.halted      = halted_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus queues expected fetch/WB/MEM/HALT events,
// an independent monitor pops and compares them as the DUT presents them.
module tb_multicycle_control_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int K_FETCH = 0;
  localparam int K_WB    = 1;
  localparam int K_MEM   = 2;
  localparam int K_HALT  = 3;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   mem_wait = 0;
  exp_t exp_q[$];

  multicycle_control_unit_if bus();

  multicycle_control_unit #(.RESET_PC(RPC), .PC_STEP(32'd4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wbv(logic [3:0] ctrl, logic src, logic mtr);
    return {24'd0, ctrl, 2'b00, src, mtr};
  endfunction

  function automatic logic [31:0] memv(logic rd, logic wr, logic [3:0] ctrl, logic src, logic [7:0] cyc);
    return {14'd0, rd, wr, 3'b000, src, ctrl, cyc};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic expect_ev(int kind, logic [31:0] val, string name);
    exp_t e;
    e.kind = kind; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic observe(int kind, logic [31:0] val);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d value %h expected no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      chk({e.name, " kind"}, 32'(kind), 32'(e.kind));
      chk(e.name, val, e.val);
    end
  endtask

  // Monitor: one negedge sample per cycle.
  initial begin
    int   mem_cycles = 0;
    logic prev_rw = 1'b0;
    logic prev_halt = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) mem_cycles++;
      else mem_cycles = 0;
      if (rst_n) begin
        if (bus.imem_req && bus.imem_ack) observe(K_FETCH, bus.imem_addr);
        if (bus.reg_write) begin
          observe(K_WB, wbv(bus.alu_control, bus.alu_src, bus.mem_to_reg));
          chk("reg_write_single_cycle", 32'(prev_rw), 32'd0);
          chk("reg_write_no_mem", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        end
        if ((bus.mem_read || bus.mem_write) && bus.dmem_ready)
          observe(K_MEM, memv(bus.mem_read, bus.mem_write, bus.alu_control, bus.alu_src, 8'(mem_cycles)));
        if (bus.halted && !prev_halt)
          observe(K_HALT, {28'd0, bus.imem_req, bus.reg_write, bus.mem_write, bus.mem_read});
        else if (bus.halted)
          chk("trap_quiet", {28'd0, bus.imem_req, bus.reg_write, bus.mem_write, bus.mem_read}, 32'd0);
      end
      prev_rw   = bus.reg_write;
      prev_halt = bus.halted;
    end
  end

  // Data-memory responder: ready after mem_wait stall cycles of an access.
  initial begin
    int cnt = 0;
    bus.dmem_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_read || bus.mem_write) begin
        bus.dmem_ready = (cnt == mem_wait);
        cnt++;
      end else begin
        bus.dmem_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  task automatic issue(string name, logic [31:0] addr, logic [31:0] insn, logic [31:0] imm,
                       logic z, logic s, int wait_n);
    int i = 0;
    while (!bus.imem_req && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    if (!bus.imem_req) begin
      checks++; errors++;
      $display("FAIL %s fetch_timeout: imem_req got 0 expected 1", name);
      return;
    end
    expect_ev(K_FETCH, addr, {name, " fetch_addr"});
    bus.imem_rdata = insn;
    bus.imem_ack   = 1'b1;
    bus.imm        = imm;
    bus.zero       = z;
    bus.sign       = s;
    mem_wait       = wait_n;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    chk({name, " instruction"}, bus.instruction, insn);
  endtask

  task automatic check_reset_outputs(string name);
    chk({name, " imem_req"}, 32'(bus.imem_req), 32'd0);
    chk({name, " pc"}, bus.pc, RPC);
    chk({name, " ctrl"}, {24'd0, bus.reg_write, bus.alu_src, bus.mem_write, bus.mem_read,
                          bus.alu_control}, 32'd0);
    chk({name, " mem_to_reg_halted"}, {30'd0, bus.mem_to_reg, bus.halted}, 32'd0);
    chk({name, " ir_nop"}, bus.instruction, 32'h0000_0013);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_pulse");
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_0013;
    bus.imm        = 32'd0;
    bus.zero       = 1'b0;
    bus.sign       = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    chk("post_reset imem_addr", bus.imem_addr, RPC);
    chk("post_reset req_low", 32'(bus.imem_req), 32'd0);
    @(posedge clk); #1;
    chk("first_req", 32'(bus.imem_req), 32'd1);

    issue("add", 32'h100, 32'h002081B3, 32'd0, 1'b0, 1'b0, 0);
    expect_ev(K_WB, wbv(4'b0000, 1'b0, 1'b0), "add wb");

    issue("lw", 32'h104, 32'h0080A283, 32'd0, 1'b0, 1'b0, 3);
    expect_ev(K_MEM, memv(1'b1, 1'b0, 4'b0000, 1'b1, 8'd4), "lw mem");
    expect_ev(K_WB, wbv(4'b0000, 1'b1, 1'b1), "lw wb");

    issue("srai", 32'h108, 32'h4030D313, 32'd0, 1'b0, 1'b0, 0);
    expect_ev(K_WB, wbv(4'b0111, 1'b1, 1'b0), "srai wb");

    issue("sub", 32'h10C, 32'h402083B3, 32'd0, 1'b0, 1'b0, 0);
    expect_ev(K_WB, wbv(4'b0001, 1'b0, 1'b0), "sub wb");

    issue("sw", 32'h110, 32'h0020A223, 32'd0, 1'b0, 1'b0, 0);
    expect_ev(K_MEM, memv(1'b0, 1'b1, 4'b0000, 1'b1, 8'd1), "sw mem");

    issue("beq_far", 32'h114, 32'h00208063, 32'hFFFF_FF2C, 1'b1, 1'b0, 0);
    issue("beq_nt",  32'h040, 32'h00208063, 32'hFFFF_FFF8, 1'b0, 1'b0, 0);
    issue("blt_t",   32'h044, 32'h0020C063, 32'hFFFF_FFFC, 1'b0, 1'b1, 0);
    issue("beq_t",   32'h040, 32'h00208063, 32'hFFFF_FFF8, 1'b1, 1'b0, 0);
    issue("bge_nt",  32'h038, 32'h0020D063, 32'h0000_0100, 1'b0, 1'b1, 0);

    issue("bad_f7", 32'h03C, 32'h4020F1B3, 32'd0, 1'b0, 1'b0, 0);
    expect_ev(K_HALT, 32'd0, "bad_f7 halt");
    repeat (8) @(posedge clk);
    #1;
    chk("bad_f7 halted", 32'(bus.halted), 32'd1);
    pulse_reset();

    issue("illegal", 32'h100, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 0);
    expect_ev(K_HALT, 32'd0, "illegal halt");
    repeat (8) @(posedge clk);
    #1;
    chk("illegal halted", 32'(bus.halted), 32'd1);
    chk("illegal req_low", 32'(bus.imem_req), 32'd0);
    pulse_reset();

    issue("add2", 32'h100, 32'h002081B3, 32'd0, 1'b0, 1'b0, 0);
    expect_ev(K_WB, wbv(4'b0000, 1'b0, 1'b0), "add2 wb");
    issue("sw_abort", 32'h104, 32'h0020A223, 32'd0, 1'b0, 1'b0, 50);
    begin
      int i = 0;
      while (!bus.mem_write && i < 20) begin
        @(posedge clk); #1;
        i++;
      end
    end
    chk("sw_abort mem_write_active", 32'(bus.mem_write), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort mem_write_drop", 32'(bus.mem_write), 32'd0);
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort refetch_req", 32'(bus.imem_req), 32'd1);

    issue("add3", 32'h100, 32'h002081B3, 32'd0, 1'b0, 1'b0, 0);
    expect_ev(K_WB, wbv(4'b0000, 1'b0, 1'b0), "add3 wb");

    repeat (6) @(posedge clk);
    #1;
    chk("add3 next_addr", bus.imem_addr, 32'h104);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
